// File: rtl/branch_predict_resolve_if.sv
// Fetch-side prediction and EX-side resolution signals of branch_predict_resolve.
// The master is the pipeline that drives fetch/EX state; the slave is the predictor.
interface branch_predict_resolve_if #(
    parameter int ADDR_W = 64
);
    // Fetch-side lookup
    logic [ADDR_W-1:0] if_pc;
    logic              if_pred_taken;
    logic [ADDR_W-1:0] if_pred_target;

    // EX-stage instruction
    logic              ex_valid;
    logic [ADDR_W-1:0] ex_pc;
    logic [ADDR_W-1:0] ex_imm;
    logic [ADDR_W-1:0] ex_reg_val;
    logic              ex_zero;
    logic [3:0]        ex_flags;
    logic [3:0]        ex_cond;
    logic              ex_uncond;
    logic              ex_branch_reg;
    logic              ex_cond_br;
    logic              ex_cmp_br;
    logic              ex_cmp_nz;
    logic              ex_pred_taken;
    logic [ADDR_W-1:0] ex_pred_target;

    // Registered recovery
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              flush;

    modport master (
        output if_pc,
        input  if_pred_taken, if_pred_target,
        output ex_valid, ex_pc, ex_imm, ex_reg_val, ex_zero, ex_flags, ex_cond,
        output ex_uncond, ex_branch_reg, ex_cond_br, ex_cmp_br, ex_cmp_nz,
        output ex_pred_taken, ex_pred_target,
        input  redirect, redirect_pc, flush
    );

    modport slave (
        input  if_pc,
        output if_pred_taken, if_pred_target,
        input  ex_valid, ex_pc, ex_imm, ex_reg_val, ex_zero, ex_flags, ex_cond,
        input  ex_uncond, ex_branch_reg, ex_cond_br, ex_cmp_br, ex_cmp_nz,
        input  ex_pred_taken, ex_pred_target,
        output redirect, redirect_pc, flush
    );
endinterface

// File: rtl/branch_predict_resolve.sv
// Direct-mapped BTB with 2-bit counters plus EX-stage branch resolution and registered redirect.
// Define BP_STATS_EN to add the stat_branches / stat_mispredicts counters.
module branch_predict_resolve #(
    parameter int ADDR_W = 64,
    parameter int IDX_W  = 4,
    parameter int TAG_W  = ADDR_W - IDX_W - 2
) (
    input  logic                   clk,
    input  logic                   reset,
    branch_predict_resolve_if.slave bus
`ifdef BP_STATS_EN
    ,
    output logic [31:0]            stat_branches,
    output logic [31:0]            stat_mispredicts
`endif
);
    localparam int DEPTH = 1 << IDX_W;

    // BTB state: valid/counter need reset, tag/target are qualified by valid
    logic              entry_valid [DEPTH];
    logic [1:0]        entry_ctr   [DEPTH];
    logic [TAG_W-1:0]  tag_mem     [DEPTH];
    logic [ADDR_W-1:0] target_mem  [DEPTH];

    logic              redirect_reg;
    logic [ADDR_W-1:0] redirect_pc_reg;

    // ------------------------------------------------------------------
    // Fetch-side lookup (combinational, sees pre-update contents)
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]  if_idx;
    logic [TAG_W-1:0]  if_tag;
    logic              if_hit;
    logic              if_taken;

    assign if_idx   = bus.if_pc[IDX_W+1:2];
    assign if_tag   = bus.if_pc[ADDR_W-1:IDX_W+2];
    assign if_hit   = entry_valid[if_idx] && (tag_mem[if_idx] == if_tag);
    assign if_taken = if_hit && entry_ctr[if_idx][1];

    assign bus.if_pred_taken  = if_taken;
    assign bus.if_pred_target = if_taken ? target_mem[if_idx] : (bus.if_pc + ADDR_W'(4));

    // ------------------------------------------------------------------
    // EX-stage resolution
    // ------------------------------------------------------------------
    logic              eff;
    logic              is_branch;
    logic              flag_n, flag_z, flag_c, flag_v;
    logic              cond_pass;
    logic              taken;
    logic [ADDR_W-1:0] imm_shift;
    logic [ADDR_W-1:0] seq_pc;
    logic [ADDR_W-1:0] branch_target;
    logic [ADDR_W-1:0] actual_next;
    logic              mispredict;

    // The EX slot during a redirect cycle holds a wrong-path instruction
    assign eff       = bus.ex_valid && !redirect_reg;
    assign is_branch = bus.ex_uncond | bus.ex_branch_reg | bus.ex_cond_br | bus.ex_cmp_br;

    assign flag_n = bus.ex_flags[3];
    assign flag_z = bus.ex_flags[2];
    assign flag_c = bus.ex_flags[1];
    assign flag_v = bus.ex_flags[0];

    always_comb begin
        cond_pass = 1'b1;
        case (bus.ex_cond)
            4'h0:    cond_pass = flag_z;
            4'h1:    cond_pass = !flag_z;
            4'h2:    cond_pass = flag_c;
            4'h3:    cond_pass = !flag_c;
            4'h4:    cond_pass = flag_n;
            4'h5:    cond_pass = !flag_n;
            4'h6:    cond_pass = flag_v;
            4'h7:    cond_pass = !flag_v;
            4'h8:    cond_pass = flag_c && !flag_z;
            4'h9:    cond_pass = !(flag_c && !flag_z);
            4'hA:    cond_pass = (flag_n == flag_v);
            4'hB:    cond_pass = (flag_n != flag_v);
            4'hC:    cond_pass = !flag_z && (flag_n == flag_v);
            4'hD:    cond_pass = !(!flag_z && (flag_n == flag_v));
            default: cond_pass = 1'b1;
        endcase
    end

    assign taken = bus.ex_uncond
                 | bus.ex_branch_reg
                 | (bus.ex_cond_br & cond_pass)
                 | (bus.ex_cmp_br & (bus.ex_zero ^ bus.ex_cmp_nz));

    // Word offset scaled to bytes; address arithmetic wraps silently
    assign imm_shift     = {bus.ex_imm[ADDR_W-3:0], 2'b00};
    assign seq_pc        = bus.ex_pc + ADDR_W'(4);
    assign branch_target = bus.ex_branch_reg ? bus.ex_reg_val : (bus.ex_pc + imm_shift);
    assign actual_next   = taken ? branch_target : seq_pc;

    assign mispredict = eff && ((bus.ex_pred_taken != taken) ||
                                (taken && (bus.ex_pred_target != branch_target)));

    // ------------------------------------------------------------------
    // BTB update decode
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]  ex_idx;
    logic [TAG_W-1:0]  ex_tag;
    logic              ex_hit;
    logic              btb_write;
    logic              btb_clear;
    logic [1:0]        ctr_next;

    assign ex_idx    = bus.ex_pc[IDX_W+1:2];
    assign ex_tag    = bus.ex_pc[ADDR_W-1:IDX_W+2];
    assign ex_hit    = entry_valid[ex_idx] && (tag_mem[ex_idx] == ex_tag);
    assign btb_write = eff && is_branch;
    // A non-branch that was predicted taken is an alias; evict it
    assign btb_clear = eff && !is_branch && bus.ex_pred_taken;

    always_comb begin
        ctr_next = 2'b01;
        if (ex_hit) begin
            ctr_next = entry_ctr[ex_idx];
            if (taken && (entry_ctr[ex_idx] != 2'b11)) begin
                ctr_next = entry_ctr[ex_idx] + 2'b01;
            end else if (!taken && (entry_ctr[ex_idx] != 2'b00)) begin
                ctr_next = entry_ctr[ex_idx] - 2'b01;
            end
        end else if (bus.ex_uncond || bus.ex_branch_reg) begin
            ctr_next = 2'b11;
        end else if (taken) begin
            ctr_next = 2'b10;
        end else begin
            ctr_next = 2'b01;
        end
    end

    // Per-entry valid/counter registers
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic       entry_sel;
            logic       valid_reg;
            logic [1:0] ctr_reg;

            assign entry_sel = (ex_idx == IDX_W'(gi));

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    valid_reg <= 1'b0;
                    ctr_reg   <= 2'b01;
                end else if (entry_sel) begin
                    if (btb_write) begin
                        valid_reg <= 1'b1;
                        ctr_reg   <= ctr_next;
                    end else if (btb_clear) begin
                        valid_reg <= 1'b0;
                    end
                end
            end

            assign entry_valid[gi] = valid_reg;
            assign entry_ctr[gi]   = ctr_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (btb_write) begin
            tag_mem[ex_idx]    <= ex_tag;
            target_mem[ex_idx] <= branch_target;
        end
    end

    // ------------------------------------------------------------------
    // Registered redirect / flush
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            redirect_reg    <= 1'b0;
            redirect_pc_reg <= '0;
        end else begin
            redirect_reg <= mispredict;
            if (mispredict) begin
                redirect_pc_reg <= actual_next;
            end
        end
    end

    assign bus.redirect    = redirect_reg;
    assign bus.flush       = redirect_reg;
    assign bus.redirect_pc = redirect_pc_reg;

`ifdef BP_STATS_EN
    logic [31:0] stat_branches_reg;
    logic [31:0] stat_mispredicts_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_branches_reg    <= '0;
            stat_mispredicts_reg <= '0;
        end else begin
            if (btb_write) begin
                stat_branches_reg <= stat_branches_reg + 32'd1;
            end
            if (mispredict) begin
                stat_mispredicts_reg <= stat_mispredicts_reg + 32'd1;
            end
        end
    end

    assign stat_branches    = stat_branches_reg;
    assign stat_mispredicts = stat_mispredicts_reg;
`endif

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Scoreboard bench for branch_predict_resolve: stimulus queues expected redirects and
// lookups, a negedge monitor pops and compares them.
module tb_branch_predict_resolve;
    localparam int ADDR_W = 64;

    localparam int T_NONE = 0;
    localparam int T_B    = 1;
    localparam int T_BR   = 2;
    localparam int T_BC   = 3;
    localparam int T_CB   = 4;

    logic clk;
    logic reset;

    branch_predict_resolve_if #(.ADDR_W(ADDR_W)) bus ();

`ifdef BP_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    branch_predict_resolve #(.ADDR_W(ADDR_W), .IDX_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef BP_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    typedef struct {
        string       name;
        logic [63:0] pc;
    } redir_exp_t;

    typedef struct {
        string       name;
        logic        taken;
        logic [63:0] target;
    } look_exp_t;

    redir_exp_t redir_q[$];
    look_exp_t  look_q[$];
    logic       lk_strobe;
    int         checks;
    int         failures;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: compares whatever the DUT presents against the queued expectations
    always @(negedge clk) begin
        redir_exp_t r;
        look_exp_t  l;
        checks++;
        if (bus.flush !== bus.redirect) begin
            failures++;
            $display("FAIL flush_eq_redirect: flush=%b redirect=%b", bus.flush, bus.redirect);
        end
        if (bus.redirect === 1'b1) begin
            checks++;
            if (redir_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_redirect: redirect_pc=0x%h, no redirect required", bus.redirect_pc);
            end else begin
                r = redir_q.pop_front();
                if (bus.redirect_pc !== r.pc) begin
                    failures++;
                    $display("FAIL %s: redirect_pc=0x%h required 0x%h", r.name, bus.redirect_pc, r.pc);
                end
            end
        end
        if (lk_strobe && look_q.size() != 0) begin
            l = look_q.pop_front();
            checks++;
            if (bus.if_pred_taken !== l.taken || bus.if_pred_target !== l.target) begin
                failures++;
                $display("FAIL %s: taken=%b target=0x%h required taken=%b target=0x%h",
                         l.name, bus.if_pred_taken, bus.if_pred_target, l.taken, l.target);
            end
        end
    end

    task automatic drive_ex(input logic [63:0] pc, input int kind, input logic [63:0] imm,
                            input logic [63:0] reg_val, input logic zero, input logic [3:0] flags,
                            input logic [3:0] cond, input logic nz, input logic ptaken,
                            input logic [63:0] ptarget);
        bus.ex_valid       = 1'b1;
        bus.ex_pc          = pc;
        bus.ex_imm         = imm;
        bus.ex_reg_val     = reg_val;
        bus.ex_zero        = zero;
        bus.ex_flags       = flags;
        bus.ex_cond        = cond;
        bus.ex_uncond      = (kind == T_B);
        bus.ex_branch_reg  = (kind == T_BR);
        bus.ex_cond_br     = (kind == T_BC);
        bus.ex_cmp_br      = (kind == T_CB);
        bus.ex_cmp_nz      = nz;
        bus.ex_pred_taken  = ptaken;
        bus.ex_pred_target = ptarget;
    endtask

    task automatic expect_redirect(input string name, input logic [63:0] pc);
        redir_exp_t r;
        r.name = name;
        r.pc   = pc;
        redir_q.push_back(r);
    endtask

    // One EX instruction followed by a bubble covering the redirect cycle
    task automatic issue(input string name, input logic [63:0] pc, input int kind,
                         input logic [63:0] imm, input logic [63:0] reg_val, input logic zero,
                         input logic [3:0] flags, input logic [3:0] cond, input logic nz,
                         input logic ptaken, input logic [63:0] ptarget,
                         input logic exp_redir, input logic [63:0] exp_pc);
        @(posedge clk);
        #1;
        if (exp_redir) expect_redirect(name, exp_pc);
        drive_ex(pc, kind, imm, reg_val, zero, flags, cond, nz, ptaken, ptarget);
        $display("issue %s pc=0x%h redirect_expected=%b next=0x%h", name, pc, exp_redir, exp_pc);
        @(posedge clk);
        #1;
        bus.ex_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input string name, input logic [63:0] pc, input logic taken,
                          input logic [63:0] target);
        look_exp_t l;
        @(posedge clk);
        #1;
        l.name   = name;
        l.taken  = taken;
        l.target = target;
        look_q.push_back(l);
        bus.if_pc = pc;
        lk_strobe = 1'b1;
        $display("lookup %s pc=0x%h expect taken=%b target=0x%h", name, pc, taken, target);
        @(posedge clk);
        #1;
        lk_strobe = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    initial begin
        checks    = 0;
        failures  = 0;
        lk_strobe = 1'b0;
        bus.if_pc = 64'h0;
        drive_ex(64'h0, T_NONE, 64'h0, 64'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 64'h0);
        bus.ex_valid = 1'b0;
        reset = 1'b0;
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        checks++;
        if (bus.redirect !== 1'b0 || bus.redirect_pc !== 64'h0) begin
            failures++;
            $display("FAIL reset_state: redirect=%b redirect_pc=0x%h required 0 / 0x0",
                     bus.redirect, bus.redirect_pc);
        end
        lookup("reset_lookup", 64'h100, 1'b0, 64'h104);

        // B at 0x100, +4 words, predicted not taken
        issue("b_0x100", 64'h100, T_B, 64'd4, 64'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 64'h0, 1'b1, 64'h110);
        lookup("b_0x100_lookup", 64'h100, 1'b1, 64'h110);

        // B.LT at 0x200, -2 words, N=1 V=0 -> taken; shares index 0 with 0x100
        issue("blt_taken", 64'h200, T_BC, -64'sd2, 64'h0, 1'b0, 4'b1000, 4'hB, 1'b0, 1'b0, 64'h0, 1'b1, 64'h1F8);
        lookup("blt_lookup_taken", 64'h200, 1'b1, 64'h1F8);
        lookup("alias_evicted_0x100", 64'h100, 1'b0, 64'h104);
        // Same B.LT with N==V: not taken, counter 10 -> 01
        issue("blt_not_taken", 64'h200, T_BC, -64'sd2, 64'h0, 1'b0, 4'b0000, 4'hB, 1'b0, 1'b1, 64'h1F8, 1'b1, 64'h204);
        lookup("blt_lookup_weak", 64'h200, 1'b0, 64'h204);

        // CBNZ with zero operand, predicted taken; wrong-path B in the redirect cycle
        @(posedge clk);
        #1;
        expect_redirect("cbnz_not_taken", 64'h304);
        drive_ex(64'h300, T_CB, 64'd8, 64'h0, 1'b1, 4'h0, 4'h0, 1'b1, 1'b1, 64'h320);
        $display("issue cbnz_not_taken pc=0x300 redirect_expected=1 next=0x304");
        @(posedge clk);
        #1;
        drive_ex(64'h144, T_B, 64'd16, 64'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 64'h0);
        $display("issue wrong_path_b pc=0x144 redirect_expected=0");
        @(posedge clk);
        #1;
        bus.ex_valid = 1'b0;
        @(posedge clk);
        #1;
        lookup("wrong_path_no_alloc", 64'h144, 1'b0, 64'h148);
        lookup("cbnz_lookup", 64'h300, 1'b0, 64'h304);

        // BR with wrong predicted target
        issue("br_target", 64'h400, T_BR, 64'h0, 64'hDEAD0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 64'hBEEF0, 1'b1, 64'hDEAD0);
        lookup("br_lookup", 64'h400, 1'b1, 64'hDEAD0);

        // Same BR again, reset asserted during its redirect cycle
        @(posedge clk);
        #1;
        drive_ex(64'h400, T_BR, 64'h0, 64'hDEAD0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 64'hBEEF0);
        $display("issue br_reset pc=0x400 redirect dropped by reset");
        @(posedge clk);
        #1;
        bus.ex_valid = 1'b0;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.redirect !== 1'b0 || bus.flush !== 1'b0) begin
            failures++;
            $display("FAIL reset_drops_redirect: redirect=%b flush=%b required 0/0", bus.redirect, bus.flush);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        lookup("after_reset_miss", 64'h400, 1'b0, 64'h404);

        // Correct prediction: no redirect, entry allocated strongly taken
        issue("b_correct", 64'h100, T_B, 64'd4, 64'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 64'h110, 1'b0, 64'h110);
        lookup("b_correct_lookup", 64'h100, 1'b1, 64'h110);
        // Non-branch predicted taken at 0x100: redirect to pc+4 and evict
        issue("nonbranch_alias", 64'h100, T_NONE, 64'h0, 64'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 64'h110, 1'b1, 64'h104);
        lookup("alias_cleared", 64'h100, 1'b0, 64'h104);

        // B.EQ not taken (Z=0), correctly predicted not taken
        issue("beq_not_taken", 64'h508, T_BC, 64'd8, 64'h0, 1'b0, 4'b0000, 4'h0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h50C);
        // B.HI taken (C=1 Z=0), predicted not taken
        issue("bhi_taken", 64'h600, T_BC, 64'd3, 64'h0, 1'b0, 4'b0010, 4'h8, 1'b0, 1'b0, 64'h0, 1'b1, 64'h60C);

        // Target wrap-around
        issue("b_wrap", 64'hFFFF_FFFF_FFFF_FFF8, T_B, 64'd4, 64'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 64'h0, 1'b1, 64'h8);
        lookup("wrap_lookup", 64'hFFFF_FFFF_FFFF_FFF8, 1'b1, 64'h8);

        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (redir_q.size() != 0 || look_q.size() != 0) begin
            failures++;
            $display("FAIL drain: pending_redirects=%0d pending_lookups=%0d required 0/0",
                     redir_q.size(), look_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/branch_predict_resolve.md
Name: branch_predict_resolve

Overview:
- Parametrised successor to the EX-stage branch calculation logic.
- Adds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, read by IF for next-PC prediction.
- Resolves CBZ/CBNZ, full B.cond (all 16 condition codes), B and BR in EX, then updates the BTB.
- Issues a registered redirect/flush one cycle after a mispredicted branch resolves.

Parameters:
- ADDR_W, 64, width of PC, immediate and register operands.
- IDX_W, 4, log2 of BTB depth (16 entries).
- TAG_W, ADDR_W-IDX_W-2, stored tag width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- if_pc  in  ADDR_W  fetch PC to predict.
- if_pred_taken  out  1  BTB predicts taken.
- if_pred_target  out  ADDR_W  predicted next PC.
- ex_valid  in  1  EX holds a valid instruction.
- ex_pc  in  ADDR_W  PC of EX instruction.
- ex_imm  in  ADDR_W  sign-extended word offset.
- ex_reg_val  in  ADDR_W  register operand (BR target / CBZ operand already reduced).
- ex_zero  in  1  CBZ operand is zero.
- ex_flags  in  4  NZCV.
- ex_cond  in  4  B.cond code.
- ex_uncond  in  1  B.
- ex_branch_reg  in  1  BR.
- ex_cond_br  in  1  B.cond.
- ex_cmp_br  in  1  CBZ/CBNZ.
- ex_cmp_nz  in  1  1 = CBNZ.
- ex_pred_taken  in  1  prediction carried from IF.
- ex_pred_target  in  ADDR_W  prediction carried from IF.
- redirect  out  1  registered mispredict pulse.
- redirect_pc  out  ADDR_W  correct next PC.
- flush  out  1  squash IF/ID/EX; equals redirect.

Behaviour:
- Reset: all BTB valid bits = 0; all counters = 2'b01; redirect = 0, flush = 0, redirect_pc = 0. Reset is asynchronous and active-high and takes effect mid-operation: a pending redirect is dropped.
- Lookup (combinational):
  - idx = if_pc[IDX_W+1:2]; tag = if_pc[ADDR_W-1:IDX_W+2].
  - Hit = valid & tag match.
  - if_pred_taken = hit & ctr[1].
  - if_pred_target = stored target when if_pred_taken, else if_pc+4.
  - A lookup that coincides with a same-index update sees the old contents (no bypass).
- Effective valid: eff = ex_valid & ~redirect. The instruction in EX during the redirect cycle is wrong-path and is ignored entirely.
- Branch type: at most one of ex_uncond / ex_branch_reg / ex_cond_br / ex_cmp_br is set. More than one set is illegal, and the result is undefined.
- Condition pass (ex_cond):
  - 0 Z; 1 ~Z; 2 C; 3 ~C; 4 N; 5 ~N; 6 V; 7 ~V.
  - 8 C&~Z; 9 ~(C&~Z); A N==V; B N!=V.
  - C ~Z&(N==V); D ~(~Z&(N==V)); E and F always true.
- Taken = ex_uncond | ex_branch_reg | (ex_cond_br & pass) | (ex_cmp_br & (ex_zero ^ ex_cmp_nz)).
- Target:
  - BR: ex_reg_val.
  - Otherwise: ex_pc + (ex_imm<<2), truncated to ADDR_W with wrap-around, no overflow flag.
- actual_next = taken ? target : ex_pc+4.
- Mispredict = eff & (ex_pred_taken != taken | (taken & ex_pred_target != target)). This includes a non-branch that was predicted taken (BTB alias), for which redirect_pc = ex_pc+4.
- Redirect timing: when mispredict holds at posedge N, redirect = flush = 1 with redirect_pc = actual_next during cycle N+1. Next cycle back to 0 unless a new mispredict occurs. Latency is 1 cycle.
- BTB update at posedge, when eff is set:
  - Branch: entry[idx(ex_pc)] gets valid = 1, tag, target.
  - Counter when the tag already matched: saturating +1 if taken, -1 if not (00 floor, 11 ceiling).
  - New allocation: counter = 11 if ex_uncond|ex_branch_reg; 10 if taken; 01 if not taken.
  - Non-branch predicted taken: clear that entry's valid.
  - Non-branch not predicted taken: no change.

Optional Feature:
- Macro BP_STATS_EN.
- Defined: adds outputs stat_branches[31:0] and stat_mispredicts[31:0].
  - stat_branches increments on each eff branch; stat_mispredicts increments on each mispredict.
  - Both wrap at 2^32 and are reset to 0.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

Test Plan:
- Reset, then if_pc=0x100 -> if_pred_taken=0, if_pred_target=0x104; redirect=0.
- EX B at ex_pc=0x100, ex_imm=4, ex_pred_taken=0 -> next cycle redirect=1, redirect_pc=0x110. Then if_pc=0x100 -> pred_taken=1, target=0x110.
- B.LT at 0x200 with imm=-2 and flags N=1,V=0 (taken, predicted not-taken) -> redirect_pc=0x1F8. Repeat with N=V -> counter steps 10 to 01, and a predicted-taken lookup now reads not taken.
- CBNZ at 0x300, ex_zero=1, predicted taken to 0x320 -> redirect_pc=0x304. The ex_valid instruction in the redirect cycle causes no BTB change and no second redirect.
- BR at 0x400, ex_reg_val=0xDEAD0, predicted taken to 0xBEEF0 -> redirect_pc=0xDEAD0, entry target updated. Assert reset during the redirect cycle -> redirect drops to 0 immediately and the BTB misses.
- Target wrap: ex_pc=0xFFFF_FFFF_FFFF_FFF8, imm=4, B -> redirect_pc=0x8.
